// File: rtl/puf_challenge_seq.sv
// Challenge sequencer for the dual-mux RO PUF: expands a seed via LFSR, drives mux selects,
// times clear/measure/drain phases per bit and collects the response. Optional: RESP_VOTE_EN (3-pass majority).
module puf_challenge_seq #(
    parameter int N_BITS        = 16,
    parameter int WIN_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       seed,
    input  logic              cmp_in,
    output logic [7:0]        sel1,
    output logic [7:0]        sel2,
    output logic              ro_enable,
    output logic              cnt_reset,
    output logic              busy,
    output logic              done,
    output logic              resp_valid,
    output logic [N_BITS-1:0] response
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SELECT  = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
    localparam logic [2:0] S_SAMPLE  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam int CNT_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int IW      = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_BITS - 1);

    logic [2:0]    state, next_state;
    logic [CW-1:0] phase_cnt;
    logic [15:0]   lfsr, lfsr_step, lfsr_nxt;
    logic [IW-1:0] bit_idx;
    logic          last_pass, accept, phase_end;

`ifdef RESP_VOTE_EN
    logic [1:0] vote_cnt, pass_cnt, vote_total;
`endif

    function automatic logic [CW-1:0] phase_len(input logic [2:0] st);
        case (st)
            S_SELECT, S_HOLD: phase_len = CW'(SETTLE_CYCLES - 1);
            S_MEASURE:        phase_len = CW'(WIN_CYCLES - 1);
            default:          phase_len = '0;
        endcase
    endfunction

    always_comb begin
        lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`ifdef RESP_VOTE_EN
        vote_total = vote_cnt + {1'b0, cmp_in};
        last_pass  = (pass_cnt == 2'd2);
`else
        last_pass  = 1'b1;
`endif
        phase_end = (phase_cnt == '0);
        accept    = (state == S_IDLE) && start && !abort;
        lfsr_nxt  = (state == S_SAMPLE && last_pass) ? lfsr_step : lfsr;

        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_LOAD;
            S_LOAD:    next_state = S_SELECT;
            S_SELECT:  if (phase_end) next_state = S_MEASURE;
            S_MEASURE: if (phase_end) next_state = S_HOLD;
            S_HOLD:    if (phase_end) next_state = S_SAMPLE;
            S_SAMPLE:  next_state = (last_pass && bit_idx == LAST_IDX) ? S_DONE : S_SELECT;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        // NOTE: abort is applied last so it overrides every transition above, including start in IDLE.
        if (abort) next_state = S_IDLE;
    end

    assign ro_enable = (state == S_MEASURE);
    assign cnt_reset = !(state == S_MEASURE || state == S_HOLD || state == S_SAMPLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            lfsr       <= '0;
            bit_idx    <= '0;
            response   <= '0;
            resp_valid <= 1'b0;
            sel1       <= '0;
            sel2       <= '0;
`ifdef RESP_VOTE_EN
            vote_cnt   <= '0;
            pass_cnt   <= '0;
`endif
        end else begin
            state <= next_state;

            if (next_state != state)
                phase_cnt <= phase_len(next_state);
            else if (!phase_end)
                phase_cnt <= phase_cnt - CW'(1);

            // Selects are registered on SELECT entry from the LFSR value that SELECT will see.
            if (next_state == S_SELECT && state != S_SELECT) begin
                sel1 <= lfsr_nxt[7:0];
                sel2 <= (lfsr_nxt[15:8] == lfsr_nxt[7:0]) ? (lfsr_nxt[15:8] ^ 8'h01)
                                                           : lfsr_nxt[15:8];
            end

            if (accept) begin
                lfsr       <= (seed == 16'h0000) ? 16'hACE1 : seed;
                bit_idx    <= '0;
                response   <= '0;
                resp_valid <= 1'b0;
`ifdef RESP_VOTE_EN
                vote_cnt   <= '0;
                pass_cnt   <= '0;
`endif
            end

            if (abort && state != S_IDLE)
                resp_valid <= 1'b0;
            else if (state == S_DONE)
                resp_valid <= 1'b1;

            if (state == S_SAMPLE && !abort) begin
`ifdef RESP_VOTE_EN
                if (last_pass) begin
                    response <= {response[N_BITS-2:0], vote_total >= 2'd2};
                    vote_cnt <= '0;
                    pass_cnt <= '0;
                end else begin
                    vote_cnt <= vote_total;
                    pass_cnt <= pass_cnt + 2'd1;
                end
`else
                response <= {response[N_BITS-2:0], cmp_in};
`endif
                if (last_pass) begin
                    lfsr    <= lfsr_step;
                    bit_idx <= bit_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_challenge_seq.sv
// Directed bench for puf_challenge_seq (N_BITS=4, WIN=8, SETTLE=2); honours RESP_VOTE_EN when defined.
module tb_puf_challenge_seq;

    localparam int N = 4;
    localparam int W = 8;
    localparam int S = 2;
`ifdef RESP_VOTE_EN
    localparam int PASSES = 3;
`else
    localparam int PASSES = 1;
`endif
    localparam int LAT  = 1 + PASSES * N * (2 * S + W + 1);
    localparam int NWIN = N * PASSES;

    logic         clk = 1'b0;
    logic         reset, start, abort;
    logic [15:0]  seed;
    logic         cmp_in = 1'b0;
    logic [7:0]   sel1, sel2;
    logic         ro_enable, cnt_reset, busy, done, resp_valid;
    logic [N-1:0] response;

    puf_challenge_seq #(.N_BITS(N), .WIN_CYCLES(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed), .cmp_in(cmp_in),
        .sel1(sel1), .sel2(sel2), .ro_enable(ro_enable), .cnt_reset(cnt_reset), .busy(busy),
        .done(done), .resp_valid(resp_valid), .response(response)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Window monitor: records per-window length, selects and preceding cnt_reset run; drives cmp_in.
    logic       pat [16];
    int         win = 0, hi_len = 0, crun = 0;
    logic       prev_ro = 1'b0;
    int         win_len [16];
    int         win_run [16];
    logic [7:0] win_s1 [16];
    logic [7:0] win_s2 [16];

    always @(negedge clk) begin
        if (start && !busy && !abort) win = 0;
        if (ro_enable && !prev_ro) begin
            if (win < 16) begin
                win_s1[win]  = sel1;
                win_s2[win]  = sel2;
                win_run[win] = crun;
            end
            hi_len = 0;
        end
        if (ro_enable) hi_len++;
        if (!ro_enable && prev_ro) begin
            if (win < 16) begin
                win_len[win] = hi_len;
                cmp_in = pat[win];
            end
            win++;
        end
        crun    = cnt_reset ? crun + 1 : 0;
        prev_ro = ro_enable;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pat(input logic [15:0] bits);
        for (int k = 0; k < 16; k++) pat[k] = bits[k];
    endtask

    task automatic pulse_start(input logic [15:0] s, output int c0);
        seed  = s;
        start = 1'b1;
        tick();
        c0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int lat);
        lat = -1;
        for (int i = 0; i < LAT + 50; i++) begin
            tick();
            if (done) begin
                lat = cyc - c0;
                break;
            end
        end
    endtask

    // Full run: latency, one-cycle done, final response and per-window timing.
    task automatic run_full(input string tag, input logic [15:0] s, input logic [N-1:0] exp_resp);
        int c0, lat;
        pulse_start(s, c0);
        wait_done(c0, lat);
        check({tag, " latency"}, lat, LAT);
        tick();
        check({tag, " done pulse width"}, done, 1'b0);
        check({tag, " resp_valid"}, resp_valid, 1'b1);
        check({tag, " response"}, response, exp_resp);
        check({tag, " window count"}, win, NWIN);
        for (int k = 0; k < NWIN; k++) begin
            check($sformatf("%s ro_enable len w%0d", tag, k), win_len[k], W);
            if (k == 0) check({tag, " cnt_reset before w0"}, win_run[0] >= S, 1'b1);
            else        check($sformatf("%s cnt_reset len w%0d", tag, k), win_run[k], S);
        end
    endtask

    task automatic check_sels(input string tag, input logic [31:0] e1, input logic [31:0] e2);
        for (int k = 0; k < NWIN; k++) begin
            check($sformatf("%s sel1 w%0d", tag, k), win_s1[k], e1[8*(k/PASSES) +: 8]);
            check($sformatf("%s sel2 w%0d", tag, k), win_s2[k], e2[8*(k/PASSES) +: 8]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sel1"}, sel1, 8'h00);
        check({tag, " sel2"}, sel2, 8'h00);
        check({tag, " ro_enable"}, ro_enable, 1'b0);
        check({tag, " cnt_reset"}, cnt_reset, 1'b1);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " resp_valid"}, resp_valid, 1'b0);
        check({tag, " response"}, response, '0);
    endtask

    initial begin
        int  c0, lat;
        logic seen;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        seed  = 16'h0000;
        set_pat(16'hFFFF);
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Seed 1, constant comparator: LFSR walks 01,02,04,08 in sel1 while sel2 stays 00.
        run_full("seed1", 16'h0001, 4'hF);
        check_sels("seed1", 32'h0804_0201, 32'h0000_0000);

        // Zero seed falls back to ACE1.
        run_full("seed0", 16'h0000, 4'hF);
        check_sels("seed0", 32'h0F87_C3E1, 32'h67B3_59AC);

        // Equal select halves: sel2 bit0 flipped.
        run_full("collide", 16'h0505, 4'hF);
        check("collide sel1 w0", win_s1[0], 8'h05);
        check("collide sel2 w0", win_s2[0], 8'h04);

        // Per-sample comparator pattern, first measurement lands in the MSB.
`ifdef RESP_VOTE_EN
        set_pat(16'b0000_010_011_100_101);
        run_full("vote", 16'h0001, 4'hA);
`else
        set_pat(16'b0000_0000_0000_1101);
        run_full("pattern", 16'h0001, 4'hB);
`endif

        // Abort during the third measurement window.
        set_pat(16'hFFFF);
        pulse_start(16'h0001, c0);
        for (int i = 0; i < LAT && !(win == 2 && ro_enable); i++) tick();
        check("abort reached w2", (win == 2) && ro_enable, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort ro_enable", ro_enable, 1'b0);
        check("abort cnt_reset", cnt_reset, 1'b1);
        check("abort busy", busy, 1'b0);
        check("abort resp_valid", resp_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < LAT + 10; i++) begin
            if (done) seen = 1'b1;
            tick();
        end
        check("abort no done", seen, 1'b0);
        run_full("after abort", 16'h0001, 4'hF);

        // Start while busy is ignored.
        pulse_start(16'h0001, c0);
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(c0, lat);
        check("busy start latency", lat, LAT);
        repeat (3) tick();
        check("busy start idle", busy, 1'b0);

        // Start and abort together in IDLE: abort wins.
        seed  = 16'h0001;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", busy, 1'b0);
        repeat (4) tick();
        check("start+abort still idle", busy, 1'b0);

        // Asynchronous reset in the middle of a measurement window.
        pulse_start(16'h0001, c0);
        for (int i = 0; i < LAT && !ro_enable; i++) tick();
        check("async reached measure", ro_enable, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async reset");
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
